// File: rtl/border_feed_ctrl.sv
// rtl/border_feed_ctrl.sv - row-border load-enable sequencer with diagonal skew
module border_feed_ctrl #(
  parameter int ROWS  = 4,
  parameter int CYC_W = 8,
  parameter int DEP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CYC_W-1:0] cfg_cycles,
  input  logic [DEP_W-1:0] cfg_depth,
  input  logic             stall,
  output logic             rd_req,
  output logic [ROWS-1:0]  row_en,
  output logic [ROWS-1:0]  row_clr,
  output logic             busy,
  output logic             done
);

  // Drain lasts ROWS-1 cycles, so the counter only needs to reach ROWS-2.
  localparam int DRW = (ROWS > 2) ? $clog2(ROWS - 1) : 1;
  localparam logic [DRW-1:0] DRAIN_LAST = DRW'((ROWS > 1) ? (ROWS - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CYC_W-1:0] r_len;
  logic [DEP_W-1:0] r_depth;
  logic [CYC_W-1:0] r_cyc;
  logic [DEP_W-1:0] r_elem;
  logic [DRW-1:0]   r_drain;

  logic             w_run;
  logic             w_base_en;
  logic             w_cyc_last;
  logic             w_elem_last;
  logic [ROWS-1:0]  w_taps;

  assign w_run       = (r_state == S_FEED) || (r_state == S_DRAIN);
  assign w_cyc_last  = (r_cyc == r_len - CYC_W'(1));
  assign w_elem_last = (r_elem == r_depth - DEP_W'(1));
  assign w_base_en   = (r_state == S_FEED) && (r_cyc == '0) && !stall;

  // Skew pipeline: tap r carries base_en delayed by r non-stalled cycles.
  generate
    if (ROWS > 1) begin : g_skew
      logic [ROWS-2:0] r_skew;

      assign w_taps = {r_skew, w_base_en};

      // Shift only on non-stalled run cycles; CLR guarantees an empty pipe.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_skew <= '0;
        end else if (r_state == S_CLR) begin
          r_skew <= '0;
        end else if (w_run && !stall) begin
          r_skew <= w_taps[ROWS-2:0];
        end
      end
    end else begin : g_noskew
      assign w_taps = w_base_en;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Configuration latch and cycle/element/drain counters; all hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len   <= '0;
      r_depth <= '0;
      r_cyc   <= '0;
      r_elem  <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len   <= (cfg_cycles == '0) ? CYC_W'(1) : cfg_cycles;
            r_depth <= cfg_depth;
          end
        end
        S_CLR: begin
          r_cyc   <= '0;
          r_elem  <= '0;
          r_drain <= '0;
        end
        S_FEED: begin
          if (!stall) begin
            if (w_cyc_last) begin
              r_cyc  <= '0;
              r_elem <= r_elem + DEP_W'(1);
            end else begin
              r_cyc <= r_cyc + CYC_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!stall) begin
            r_drain <= r_drain + DRW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_next  = r_state;
    rd_req  = 1'b0;
    row_en  = '0;
    row_clr = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_CLR;
        end
      end
      S_CLR: begin
        busy    = 1'b1;
        row_clr = '1;
        w_next  = (r_depth != '0) ? S_FEED : S_DONE;
      end
      S_FEED: begin
        busy   = 1'b1;
        rd_req = w_base_en;
        if (!stall) begin
          row_en = w_taps;
          if (w_cyc_last && w_elem_last) begin
            w_next = (ROWS > 1) ? S_DRAIN : S_DONE;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!stall) begin
          row_en = w_taps;
          if (r_drain == DRAIN_LAST) begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_border_feed_ctrl.sv
// tb/tb_border_feed_ctrl.sv - randomized and directed bench for border_feed_ctrl
module tb_border_feed_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [7:0] cfg_cycles = 8'd0;
  logic [7:0] cfg_depth = 8'd0;

  logic       rd4, busy4, done4;
  logic [3:0] en4, clr4;
  logic       rd1, busy1, done1;
  logic [0:0] en1, clr1;

  border_feed_ctrl #(.ROWS(4), .CYC_W(8), .DEP_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_cycles(cfg_cycles),
    .cfg_depth(cfg_depth), .stall(stall), .rd_req(rd4), .row_en(en4),
    .row_clr(clr4), .busy(busy4), .done(done4)
  );

  border_feed_ctrl #(.ROWS(1), .CYC_W(8), .DEP_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_cycles(cfg_cycles),
    .cfg_depth(cfg_depth), .stall(stall), .rd_req(rd1), .row_en(en1),
    .row_clr(clr1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Reference model: a run is a sequence of K*L+ROWS-1 active (non-stalled)
  // steps; row r loads element k on active step k*L + r.
  int m_ph[2];   // 0 idle, 1 clear, 2 run, 3 done
  int m_l[2];
  int m_k[2];
  int m_a[2];
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0; m_l[i] = 1; m_k[i] = 0; m_a[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int rows;
      int e_rd, e_en, e_clr, e_busy, e_done;
      int a_rd, a_en, a_clr, a_busy, a_done;
      rows = (i == 0) ? 4 : 1;
      e_rd = 0; e_en = 0; e_clr = 0; e_busy = 0; e_done = 0;
      if (!rst_n) begin
        m_ph[i] = 0;
      end else begin
        case (m_ph[i])
          0: begin
            if (start) begin
              m_l[i]  = (cfg_cycles == 0) ? 1 : int'(cfg_cycles);
              m_k[i]  = int'(cfg_depth);
              m_ph[i] = 1;
            end
          end
          1: begin
            e_busy = 1;
            e_clr  = (1 << rows) - 1;
            m_a[i] = 0;
            m_ph[i] = (m_k[i] > 0) ? 2 : 3;
          end
          2: begin
            e_busy = 1;
            if (!stall) begin
              for (int r = 0; r < rows; r++) begin
                int d;
                d = m_a[i] - r;
                if (d >= 0 && d < m_k[i] * m_l[i] && (d % m_l[i]) == 0) e_en |= (1 << r);
              end
              e_rd = (m_a[i] < m_k[i] * m_l[i] && (m_a[i] % m_l[i]) == 0) ? 1 : 0;
              m_a[i]++;
              if (m_a[i] == m_k[i] * m_l[i] + rows - 1) m_ph[i] = 3;
            end
          end
          default: begin
            e_busy = 1;
            e_done = 1;
            m_ph[i] = 0;
          end
        endcase
      end
      if (i == 0) begin
        a_rd = int'(rd4); a_en = int'(en4); a_clr = int'(clr4);
        a_busy = int'(busy4); a_done = int'(done4);
      end else begin
        a_rd = int'(rd1); a_en = int'(en1); a_clr = int'(clr1);
        a_busy = int'(busy1); a_done = int'(done1);
      end
      check($sformatf("model_rd_req[R%0d]", rows), a_rd, e_rd);
      check($sformatf("model_row_en[R%0d]", rows), a_en, e_en);
      check($sformatf("model_row_clr[R%0d]", rows), a_clr, e_clr);
      check($sformatf("model_busy[R%0d]", rows), a_busy, e_busy);
      check($sformatf("model_done[R%0d]", rows), a_done, e_done);
    end
  end

  // Event log for the hand-computed timing checks.
  int en0_q[$], en3_q[$], rd_q[$], done_q[$], done1_q[$];
  int clr_t, clr_v, busy_n, en_in_stall;

  always @(negedge clk) begin
    if (clr4 != 0) begin clr_t = cyc; clr_v = int'(clr4); end
    if (en4[0]) en0_q.push_back(cyc);
    if (en4[3]) en3_q.push_back(cyc);
    if (rd4) rd_q.push_back(cyc);
    if (done4) done_q.push_back(cyc);
    if (done1) done1_q.push_back(cyc);
    if (busy4) busy_n++;
    if (stall && en4 != 0) en_in_stall++;
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input int l, input int k, output int t);
    start = 1'b1;
    cfg_cycles = 8'(l);
    cfg_depth = 8'(k);
    t = cyc;
    en0_q.delete(); en3_q.delete(); rd_q.delete(); done_q.delete(); done1_q.delete();
    clr_t = -1; clr_v = -1; busy_n = 0; en_in_stall = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int t;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_outputs", int'({rd4, en4, clr4, busy4, done4}), 0);
    rst_n = 1'b1;
    goto(cyc + 2);

    // Basic run with an ignored start carrying different cfg in the middle.
    launch(4, 2, t);
    goto(t + 5);
    start = 1'b1; cfg_cycles = 8'd1; cfg_depth = 8'd7;
    goto(t + 6);
    start = 1'b0;
    goto(t + 20);
    check("basic_clr_time", clr_t, t + 1);
    check("basic_clr_value", clr_v, 15);
    check("basic_en0_count", en0_q.size(), 2);
    check("basic_en0_first", qat(en0_q, 0), t + 2);
    check("basic_en0_second", qat(en0_q, 1), t + 6);
    check("basic_en3_first", qat(en3_q, 0), t + 5);
    check("basic_en3_second", qat(en3_q, 1), t + 9);
    check("basic_rd_count", rd_q.size(), 2);
    check("basic_rd_first", qat(rd_q, 0), t + 2);
    check("basic_rd_second", qat(rd_q, 1), t + 6);
    check("basic_done_count", done_q.size(), 1);
    check("basic_done_time", qat(done_q, 0), t + 13);
    check("basic_busy_cycles", busy_n, 13);
    check("rows1_done_time", qat(done1_q, 0), t + 10);

    // Three stalled cycles starting at t+4.
    launch(4, 2, t);
    goto(t + 4);
    stall = 1'b1;
    goto(t + 7);
    stall = 1'b0;
    goto(t + 22);
    check("stall_en3_count", en3_q.size(), 2);
    check("stall_en3_first", qat(en3_q, 0), t + 8);
    check("stall_en3_second", qat(en3_q, 1), t + 12);
    check("stall_done_time", qat(done_q, 0), t + 16);
    check("stall_rd_count", rd_q.size(), 2);
    check("stall_no_en", en_in_stall, 0);

    // Zero stream length behaves as L=1.
    launch(0, 3, t);
    goto(t + 12);
    check("l0_en0_count", en0_q.size(), 3);
    check("l0_en0_a", qat(en0_q, 0), t + 2);
    check("l0_en0_b", qat(en0_q, 1), t + 3);
    check("l0_en0_c", qat(en0_q, 2), t + 4);
    check("l0_done_time", qat(done_q, 0), t + 8);

    // Zero depth: clear then done.
    launch(3, 0, t);
    goto(t + 6);
    check("k0_clr_time", clr_t, t + 1);
    check("k0_done_time", qat(done_q, 0), t + 2);
    check("k0_no_en", en0_q.size() + en3_q.size(), 0);
    check("k0_no_rd", rd_q.size(), 0);

    // Asynchronous reset in the middle of FEED.
    launch(4, 2, t);
    goto(t + 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs4", int'({rd4, en4, clr4, busy4, done4}), 0);
    check("async_reset_outputs1", int'({rd1, en1, clr1, busy1, done1}), 0);
    goto(t + 9);
    rst_n = 1'b1;
    goto(t + 20);
    check("reset_no_done", done_q.size() + done1_q.size(), 0);
    launch(4, 2, t);
    goto(t + 20);
    check("after_reset_done", qat(done_q, 0), t + 13);
    check("after_reset_en3", qat(en3_q, 1), t + 9);

    // Maximum stream length.
    launch(255, 2, t);
    goto(t + 520);
    check("maxlen_done_time", qat(done_q, 0), t + 515);
    check("maxlen_rows1_done", qat(done1_q, 0), t + 512);

    // Random stimulus, checked cycle by cycle against the model.
    for (int n = 0; n < 1500; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      start = ($urandom_range(0, 7) == 0);
      cfg_cycles = 8'($urandom_range(0, 5));
      cfg_depth = 8'($urandom_range(0, 4));
      rst_n = ($urandom_range(0, 199) != 0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1; start = 1'b0; stall = 1'b0;
    goto(cyc + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
